// File: rtl/lfsr_pkg.sv
// lfsr_pkg: default tap masks and the single-step shift function for lfsr_gen
package lfsr_pkg;
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h80200003;
  function automatic logic [31:0] default_taps(input int w);
    return w == 4 ? 32'(TAPS_4) : w == 8 ? 32'(TAPS_8) : w == 32 ? TAPS_32 : 32'(TAPS_16);
  endfunction
  // Callers zero-extend state and taps and truncate the result to their own width
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] t);
    return {s[30:0], ^(s & t)};
  endfunction
endpackage

// File: rtl/lfsr_period_mon.sv
// lfsr_period_mon: counts advances from the start value and reports the period on each return to it
module lfsr_period_mon #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] start_i,
  input  logic [WIDTH-1:0] next_i,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o
);
  logic [WIDTH-1:0] r_start, r_cnt, r_period, w_inc;
  logic             r_wrap, w_wrap;
  assign w_inc  = &r_cnt ? r_cnt : r_cnt + 1'b1;
  assign w_wrap = !load_i && adv_i && next_i == r_start;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_start  <= SEED;
      r_cnt    <= '0;
      r_period <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_start  <= load_i ? start_i : r_start;
      r_cnt    <= (load_i || w_wrap) ? '0 : adv_i ? w_inc : r_cnt;
      r_period <= w_wrap ? w_inc : r_period;
      r_wrap   <= w_wrap;
    end
  end
  assign wrap_o   = r_wrap;
  assign period_o = r_period;
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed loading, zero-seed protection and period monitor
module lfsr_gen import lfsr_pkg::*; #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
  parameter int STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             next_i,
  output logic [WIDTH-1:0] rand_o,
  output logic             seed_err_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o
);
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_gen: TAPS must include the top bit");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_gen: STEP must be 1..WIDTH");
  end
  logic [WIDTH-1:0] r_state, w_next, w_load_val;
  logic             r_seed_err, w_zero;
  // STEP single shifts folded into one combinational advance
  always_comb begin
    w_next = r_state;
    for (int i = 0; i < STEP; i++) w_next = WIDTH'(lfsr_step(32'(w_next), 32'(TAPS)));
  end
  assign w_zero     = seed_i == '0;
  assign w_load_val = w_zero ? SEED : seed_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= SEED;
      r_seed_err <= 1'b0;
    end else begin
      r_state    <= load_i ? w_load_val : next_i ? w_next : r_state;
      r_seed_err <= load_i && w_zero;
    end
  end
  lfsr_period_mon #(.WIDTH(WIDTH), .SEED(SEED)) u_mon (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_i),
    .adv_i   (next_i),
    .start_i (w_load_val),
    .next_i  (w_next),
    .wrap_o  (wrap_o),
    .period_o(period_o)
  );
  assign rand_o     = r_state;
  assign seed_err_o = r_seed_err;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: three generator configurations checked against an arithmetic reference model
module tb_lfsr_gen;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, nxt = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] r0, r1, p0, p1;
  logic [3:0]  r2, p2;
  logic        e0, e1, e2, w0, w1, w2;
  int passed = 0, total = 0, fails = 0, wraps = 0;
  logic [31:0] MASK [3] = '{32'hFFFF, 32'hFFFF, 32'hF};
  logic [31:0] TP   [3] = '{32'hD008, 32'hD008, 32'hC};
  int          ST   [3] = '{1, 4, 1};
  logic [31:0] ms [3], mst [3], mc [3], mp [3];
  logic        mw [3], me [3];
  always #5 clk = ~clk;
  lfsr_gen u0 (.clk_i(clk), .rst_i(rst), .load_i(load), .seed_i(seed), .next_i(nxt),
    .rand_o(r0), .seed_err_o(e0), .wrap_o(w0), .period_o(p0));
  lfsr_gen #(.STEP(4)) u1 (.clk_i(clk), .rst_i(rst), .load_i(load), .seed_i(seed), .next_i(nxt),
    .rand_o(r1), .seed_err_o(e1), .wrap_o(w1), .period_o(p1));
  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u2 (.clk_i(clk), .rst_i(rst), .load_i(load),
    .seed_i(seed[3:0]), .next_i(nxt), .rand_o(r2), .seed_err_o(e2), .wrap_o(w2), .period_o(p2));
  // Successor: multiply by x modulo 2^W, feedback bit is the parity of the tapped bits
  function automatic logic [31:0] succ(input int k, input logic [31:0] s);
    for (int i = 0; i < ST[k]; i++) s = ((s << 1) | 32'($countones(s & TP[k]) % 2)) & MASK[k];
    return s;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ms[k] = 1; mst[k] = 1; mc[k] = 0; mp[k] = 0; mw[k] = 0; me[k] = 0;
    end
  endtask
  task automatic model_tick();
    logic [31:0] sd;
    for (int k = 0; k < 3; k++) begin
      sd = 32'(seed) & MASK[k];
      mw[k] = 0; me[k] = 0;
      if (load) begin
        ms[k] = sd == 0 ? 1 : sd; mst[k] = ms[k]; mc[k] = 0; me[k] = sd == 0;
      end else if (nxt) begin
        ms[k] = succ(k, ms[k]);
        if (ms[k] == mst[k]) begin
          mw[k] = 1; mp[k] = mc[k] == MASK[k] ? MASK[k] : mc[k] + 1; mc[k] = 0;
        end else mc[k] = mc[k] == MASK[k] ? MASK[k] : mc[k] + 1;
      end
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("rand0", r0, ms[0]); chk("err0", e0, me[0]); chk("wrap0", w0, mw[0]); chk("per0", p0, mp[0]);
    chk("rand1", r1, ms[1]); chk("err1", e1, me[1]); chk("wrap1", w1, mw[1]); chk("per1", p1, mp[1]);
    chk("rand2", r2, ms[2]); chk("err2", e2, me[2]); chk("wrap2", w2, mw[2]); chk("per2", p2, mp[2]);
  endtask
  task automatic step();
    @(posedge clk);
    model_tick();
    #1 check_all();
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    chk("reset_rand", r0, 16'h0001);
    rst = 1'b0;
    nxt = 1'b1;
    step(); chk("seq_1", r0, 16'h0002); chk("step4_adv", r1, 16'h0011);
    step(); chk("seq_2", r0, 16'h0004);
    step(); chk("seq_3", r0, 16'h0008);
    step(); chk("seq_4", r0, 16'h0011);
    nxt = 1'b0; load = 1'b1; seed = 16'h0000;
    step(); chk("zero_seed_rand", r0, 16'h0001); chk("zero_seed_err", e0, 1'b1);
    load = 1'b0;
    step(); chk("zero_seed_err_clear", e0, 1'b0);
    load = 1'b1; seed = 16'hACE1;
    step(); chk("load_rand", r0, 16'hACE1); chk("load_err", e0, 1'b0);
    nxt = 1'b1; seed = 16'h1234;
    step(); chk("load_wins", r0, 16'h1234);
    load = 1'b0;
    step(); chk("after_load_adv", r0, 16'h2469);
    for (int i = 0; i < 300; i++) begin
      load = $urandom_range(0, 15) == 0;
      nxt  = $urandom_range(0, 3) != 0;
      seed = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom);
      step();
    end
    load = 1'b1; nxt = 1'b0; seed = 16'h0001;
    step();
    load = 1'b0; nxt = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (w2) wraps++;
      if (i == 15) begin
        chk("w4_wrap", w2, 1'b1); chk("w4_period", p2, 4'd15);
      end
    end
    chk("w4_wrap_count", wraps, 3);
    load = 1'b1; nxt = 1'b0;
    step();
    load = 1'b0; nxt = 1'b1;
    for (int i = 1; i <= 65535; i++) step();
    chk("w16_wrap", w0, 1'b1); chk("w16_period", p0, 16'd65535);
    step(); step();
    rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_rand", r0, 16'h0001); chk("rst_period", p0, 16'h0000);
    @(negedge clk) rst = 1'b0;
    step(); chk("post_rst_adv", r0, 16'h0002);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
